// File: rtl/xs3_pkg.sv
// Shared constants and state encoding for the Excess-3 to ASCII
// transmit path.
package xs3_pkg;

  localparam logic [3:0] XS3_OFFSET = 4'd3;
  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_ONE  = 8'h31;
  localparam logic [7:0] ASCII_ERR  = 8'h3F;

  typedef enum logic [1:0] {
    IDLE,
    CARRY,
    DIGIT,
    TERM
  } state_t;

endpackage

// File: rtl/xs3_digit_to_ascii.sv
// One Excess-3 code to its ASCII digit, or '?' with an invalid
// flag for codes outside 3..12.
module xs3_digit_to_ascii
  import xs3_pkg::*;
(
  input  logic [3:0] code,
  output logic [7:0] ascii,
  output logic       invalid
);

  logic [3:0] dec;

  assign invalid = (code < XS3_OFFSET) || (code > 4'd12);
  assign dec     = code - XS3_OFFSET;
  assign ascii   = invalid ? ASCII_ERR
                           : ({4'h0, dec} + ASCII_ZERO);

endmodule

// File: rtl/xs3_ascii_tx.sv
// Streams an Excess-3 result word as ASCII, most significant digit
// first, followed by a terminator byte.
module xs3_ascii_tx
  import xs3_pkg::*;
#(
  parameter int         NDIG        = 4,
  parameter logic [7:0] TERM_CHAR   = 8'h0D,
  parameter bit         SUPPRESS_LZ = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_valid,
  output logic            load_ready,
  input  logic [4*NDIG-1:0] xs3_in,
  input  logic            carry_in,
  output logic [7:0]      tx_data,
  output logic            tx_valid,
  input  logic            tx_ready,
  output logic            busy,
  output logic            err
);

  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [IW-1:0] TOP = IW'(NDIG - 1);

  state_t            state;
  logic [4*NDIG-1:0] word;
  logic [IW-1:0]     idx;
  logic [IW-1:0]     sel;
  logic [3:0]        code;
  logic [7:0]        ascii;
  logic              bad;
  logic              skip;

  assign load_ready = (state == IDLE);

  // sel is the digit that will be presented on the next edge
  always_comb begin
    sel = TOP;
    if (state == DIGIT) begin
      if (!tx_valid)
        sel = idx;
      else if (idx != '0)
        sel = idx - IW'(1);
      else
        sel = '0;
    end
  end

  assign code = (state == IDLE) ? xs3_in[{sel, 2'b00} +: 4]
                                : word[{sel, 2'b00} +: 4];

  // only consulted before any character of the word is out
  assign skip = SUPPRESS_LZ && (code == XS3_OFFSET) && (sel != '0);

  xs3_digit_to_ascii u_dec (
    .code    (code),
    .ascii   (ascii),
    .invalid (bad)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      word     <= '0;
      idx      <= '0;
      tx_data  <= 8'h00;
      tx_valid <= 1'b0;
      busy     <= 1'b0;
      err      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (load_valid) begin
            word <= xs3_in;
            busy <= 1'b1;
            err  <= 1'b0;
            if (carry_in) begin
              state    <= CARRY;
              idx      <= TOP;
              tx_data  <= ASCII_ONE;
              tx_valid <= 1'b1;
            end else if (skip) begin
              state <= DIGIT;
              idx   <= sel - IW'(1);
            end else begin
              state    <= DIGIT;
              idx      <= sel;
              tx_data  <= ascii;
              tx_valid <= 1'b1;
              err      <= bad;
            end
          end
        end
        CARRY: begin
          if (tx_ready) begin
            state   <= DIGIT;
            idx     <= sel;
            tx_data <= ascii;
            err     <= err | bad;
          end
        end
        DIGIT: begin
          if (!tx_valid) begin
            if (skip) begin
              idx <= sel - IW'(1);
            end else begin
              idx      <= sel;
              tx_data  <= ascii;
              tx_valid <= 1'b1;
              err      <= err | bad;
            end
          end else if (tx_ready) begin
            if (idx == '0) begin
              state   <= TERM;
              tx_data <= TERM_CHAR;
            end else begin
              idx     <= sel;
              tx_data <= ascii;
              err     <= err | bad;
            end
          end
        end
        TERM: begin
          if (tx_ready) begin
            state    <= IDLE;
            tx_valid <= 1'b0;
            busy     <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xs3_ascii_tx.sv
// Scoreboard bench for xs3_ascii_tx: stimulus queues expected bytes,
// a negedge monitor pops them on every tx handshake.
module tb_xs3_ascii_tx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [15:0] xs3_in = '0;
  logic        carry_in = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic        busy;
  logic        err;

  int checks = 0;
  int errors = 0;
  logic [7:0] expq[$];

  always #5 clk = ~clk;

  xs3_ascii_tx #(
    .NDIG        (4),
    .TERM_CHAR   (8'h0D),
    .SUPPRESS_LZ (1'b1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .xs3_in     (xs3_in),
    .carry_in   (carry_in),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .busy       (busy),
    .err        (err)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: inputs change only at posedge+1, so negedge sees
  // exactly what the next posedge will sample.
  always @(negedge clk) begin
    if (rst_n && tx_valid && tx_ready) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_tx: got %h expected none", tx_data);
      end else begin
        chk("tx_data", {24'h0, tx_data}, {24'h0, expq.pop_front()});
      end
    end
  end

  task automatic push(input logic [7:0] b);
    expq.push_back(b);
  endtask

  // Returns at accept edge + 1
  task automatic load_word(input logic [15:0] w, input logic c);
    bit ok;
    @(posedge clk);
    #1;
    xs3_in     = w;
    carry_in   = c;
    load_valid = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (load_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL load_timeout: got busy expected load_ready");
    end
    @(posedge clk);
    #1;
    load_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (!busy && expq.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_done: got busy=%b q=%0d expected idle",
               name, busy, expq.size());
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
    chk("rst_tx_data", {24'h0, tx_data}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_err", {31'h0, err}, 32'h0);
    chk("rst_load_ready", {31'h0, load_ready}, 32'h1);
    rst_n = 1'b1;

    // Test 1: full rate, one char per cycle
    push(8'h31); push(8'h32); push(8'h33); push(8'h34); push(8'h0D);
    load_word(16'h4567, 1'b0);
    chk("t1_first_valid", {31'h0, tx_valid}, 32'h1);
    chk("t1_first_data", {24'h0, tx_data}, 32'h31);
    repeat (5) @(posedge clk);
    #1;
    chk("t1_busy_after", {31'h0, busy}, 32'h0);
    chk("t1_ready_after", {31'h0, load_ready}, 32'h1);
    chk("t1_q_empty", expq.size(), 32'h0);

    // Test 2: leading zeros dropped
    push(8'h35); push(8'h0D);
    load_word(16'h3338, 1'b0);
    wait_done("t2");
    chk("t2_err", {31'h0, err}, 32'h0);

    // Test 3: all-zero word, without and with carry
    push(8'h30); push(8'h0D);
    load_word(16'h3333, 1'b0);
    wait_done("t3a");
    push(8'h31); push(8'h30); push(8'h30); push(8'h30); push(8'h30);
    push(8'h0D);
    load_word(16'h3333, 1'b1);
    wait_done("t3b");

    // Test 4: invalid digit, sticky err
    push(8'h31); push(8'h3F); push(8'h32); push(8'h0D);
    load_word(16'h34F5, 1'b0);
    chk("t4_err_clear_at_load", {31'h0, err}, 32'h0);
    @(posedge clk);
    #1;
    chk("t4_err_before_q", {31'h0, err}, 32'h0);
    @(posedge clk);
    #1;
    chk("t4_q_data", {24'h0, tx_data}, 32'h3F);
    chk("t4_err_at_q", {31'h0, err}, 32'h1);
    wait_done("t4");
    chk("t4_err_sticky", {31'h0, err}, 32'h1);

    // Test 5: backpressure on '2', loads ignored; err clears on load
    push(8'h31); push(8'h32); push(8'h33); push(8'h34); push(8'h0D);
    load_word(16'h4567, 1'b0);
    chk("t5_err_cleared", {31'h0, err}, 32'h0);
    @(posedge clk);
    #1;
    tx_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      load_valid = i[0];
      xs3_in     = 16'h9999;
      carry_in   = 1'b1;
      @(posedge clk);
      #1;
      chk("t5_stall_valid", {31'h0, tx_valid}, 32'h1);
      chk("t5_stall_data", {24'h0, tx_data}, 32'h32);
    end
    load_valid = 1'b0;
    tx_ready   = 1'b1;
    wait_done("t5");

    // Test 6: reset while second char presented
    push(8'h3F);
    load_word(16'hF567, 1'b0);
    chk("t6_err_set", {31'h0, err}, 32'h1);
    @(posedge clk);
    #1;
    chk("t6_second", {24'h0, tx_data}, 32'h32);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("t6_tx_valid", {31'h0, tx_valid}, 32'h0);
    chk("t6_tx_data", {24'h0, tx_data}, 32'h0);
    chk("t6_busy", {31'h0, busy}, 32'h0);
    chk("t6_err", {31'h0, err}, 32'h0);
    chk("t6_load_ready", {31'h0, load_ready}, 32'h1);
    repeat (10) @(posedge clk);
    #1;
    chk("t6_q_empty", expq.size(), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
